// File: rtl/alarm_delay_controller.sv
// rtl/alarm_delay_controller.sv - arm/disarm sequencer with timed exit/entry delays
// Drives an external load/enable up-counter and detects delay expiry from its Qout.
module alarm_delay_controller #(
  parameter int TICK_DIV    = 50000000,
  parameter int CNT_WIDTH   = 3,
  parameter int EXIT_TICKS  = 7,
  parameter int ENTRY_TICKS = 5
) (
  input  logic                 clock50,
  input  logic                 Mr_n,
  input  logic                 arm,
  input  logic                 disarm,
  input  logic                 sensor,
  input  logic [CNT_WIDTH-1:0] cnt_q,
  output logic                 cnt_load,
  output logic [CNT_WIDTH-1:0] cnt_load_value,
  output logic                 cnt_en,
  output logic [2:0]           state,
  output logic                 armed_led,
  output logic                 delay_active,
  output logic                 siren
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] EXIT_LOAD  = CNT_MAX - CNT_WIDTH'(EXIT_TICKS);
  localparam logic [CNT_WIDTH-1:0] ENTRY_LOAD = CNT_MAX - CNT_WIDTH'(ENTRY_TICKS);

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_EXIT_DELAY  = 3'd1,
    ST_ARMED       = 3'd2,
    ST_ENTRY_DELAY = 3'd3,
    ST_ALARM       = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic                   load_q, load_d;
  logic [CNT_WIDTH-1:0]   load_value_q, load_value_d;
  logic                   in_delay, next_in_delay, enter_delay, tick, expiry;

  // Load pulse masks expiry/enable for the cycle before the counter holds the new value.
  always_comb begin
    in_delay = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY);
    tick     = (presc_q == TICK_LAST);
    expiry   = in_delay && !load_q && (cnt_q == CNT_MAX);
    cnt_en   = tick && in_delay && !load_q && (cnt_q != CNT_MAX);
  end

  always_comb begin
    state_d = state_q;
    if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED:    if (arm)    state_d = ST_EXIT_DELAY;
        ST_EXIT_DELAY:  if (expiry) state_d = ST_ARMED;
        ST_ARMED:       if (sensor) state_d = ST_ENTRY_DELAY;
        ST_ENTRY_DELAY: if (expiry) state_d = ST_ALARM;
        ST_ALARM:       state_d = ST_ALARM;
        default:        state_d = ST_DISARMED;
      endcase
    end
  end

  always_comb begin
    next_in_delay = (state_d == ST_EXIT_DELAY) || (state_d == ST_ENTRY_DELAY);
    enter_delay   = next_in_delay && (state_d != state_q);
    load_d        = enter_delay;
    load_value_d  = load_value_q;
    if (enter_delay) begin
      load_value_d = (state_d == ST_EXIT_DELAY) ? EXIT_LOAD : ENTRY_LOAD;
    end
    presc_d = '0;
    if (next_in_delay && !enter_delay && !tick) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock50 or negedge Mr_n) begin
    if (!Mr_n) begin
      state_q      <= ST_DISARMED;
      presc_q      <= '0;
      load_q       <= 1'b0;
      load_value_q <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      load_q       <= load_d;
      load_value_q <= load_value_d;
    end
  end

  assign state          = state_q;
  assign cnt_load       = load_q;
  assign cnt_load_value = load_value_q;
  assign armed_led      = (state_q == ST_ARMED) || (state_q == ST_ENTRY_DELAY);
  assign delay_active   = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY);
  assign siren          = (state_q == ST_ALARM);

endmodule

// File: tb/tb_alarm_delay_controller.sv
// tb/tb_alarm_delay_controller.sv - bench for alarm_delay_controller with a 3-bit counter
// Reference model tracks state and elapsed cycles since delay entry.
module tb_alarm_delay_controller;
  localparam int TD = 4, CW = 3, EX = 3, EN = 2, CMAX = 7;

  logic          clk = 1'b0;
  logic          mr_n = 1'b0, arm = 1'b0, disarm = 1'b0, sensor = 1'b0;
  logic [CW-1:0] cnt_q;
  logic          cnt_load, cnt_en, armed_led, delay_active, siren;
  logic [CW-1:0] cnt_load_value;
  logic [2:0]    state;

  int n_checks = 0, n_fail = 0;
  int m_st, m_k, m_lv, m_cnt;
  bit m_load;

  always #5 clk = ~clk;

  alarm_delay_controller #(
    .TICK_DIV(TD), .CNT_WIDTH(CW), .EXIT_TICKS(EX), .ENTRY_TICKS(EN)
  ) dut (
    .clock50(clk), .Mr_n(mr_n), .arm(arm), .disarm(disarm), .sensor(sensor),
    .cnt_q(cnt_q), .cnt_load(cnt_load), .cnt_load_value(cnt_load_value),
    .cnt_en(cnt_en), .state(state), .armed_led(armed_led),
    .delay_active(delay_active), .siren(siren)
  );

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n)         cnt_q <= '0;
    else if (cnt_load) cnt_q <= cnt_load_value;
    else if (cnt_en)   cnt_q <= cnt_q + 3'd1;
  end

  task automatic model_reset();
    m_st = 0; m_k = 0; m_lv = 0; m_cnt = 0; m_load = 0;
  endtask

  // Counter value in a delay is load + elapsed/TICK_DIV, saturating at the maximum.
  task automatic model_edge();
    int nst, n;
    bit enter;
    nst = m_st; enter = 0;
    if (disarm) nst = 0;
    else case (m_st)
      0: if (arm) begin nst = 1; enter = 1; end
      1: if (m_k == EX * TD) nst = 2;
      2: if (sensor) begin nst = 3; enter = 1; end
      3: if (m_k == EN * TD) nst = 4;
      default: ;
    endcase
    if (m_st == 1 || m_st == 3) begin
      n = m_lv + (m_k + 1) / TD;
      m_cnt = (n > CMAX) ? CMAX : n;
    end
    if (enter) begin
      m_k = 0;
      m_lv = CMAX - ((nst == 1) ? EX : EN);
    end else if (nst == m_st) begin
      m_k++;
    end
    m_load = enter;
    m_st = nst;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    mr_n = 0; arm = 0; disarm = 0; sensor = 0;
    @(negedge clk);
    mr_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({state, cnt_load, cnt_load_value, cnt_en, armed_led, delay_active, siren} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got state=%0d load=%0b lv=%0d en=%0b leds=%0b%0b%0b want all 0",
        state, cnt_load, cnt_load_value, cnt_en, armed_led, delay_active, siren);
    end
    arm = 1; step(); arm = 0;
    repeat (13) step();
    sensor = 1; step(); sensor = 0;
    repeat (9) step();
    n_checks++;
    if (state !== 3'd4 || siren !== 1'b1) begin
      n_fail++; $display("FAIL reach_alarm: got state=%0d siren=%0b want 4/1", state, siren);
    end
    #2 mr_n = 0;
    #1;
    n_checks++;
    if ({state, cnt_load, cnt_load_value, cnt_en, armed_led, delay_active, siren} !== '0) begin
      n_fail++; $display("FAIL async_reset: got state=%0d load=%0b lv=%0d en=%0b siren=%0b want all 0",
        state, cnt_load, cnt_load_value, cnt_en, siren);
    end
    @(negedge clk);
    mr_n = 1;
    model_reset();
    step();
    n_checks++;
    if (state !== 3'd0 || cnt_load !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got state=%0d load=%0b want 0/0", state, cnt_load);
    end
  endtask

  task automatic test_arm();
    int got;
    logic [CW-1:0] seq [4];
    apply_reset();
    arm = 1; step(); arm = 0;
    n_checks++;
    if (state !== 3'd1 || cnt_load !== 1'b1 || cnt_load_value !== 3'd4) begin
      n_fail++; $display("FAIL arm_entry: got state=%0d load=%0b lv=%0d want 1/1/4", state, cnt_load, cnt_load_value);
    end
    n_checks++;
    if (delay_active !== 1'b1 || armed_led !== 1'b0) begin
      n_fail++; $display("FAIL arm_leds: got delay=%0b armed=%0b want 1/0", delay_active, armed_led);
    end
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) seq[0] = cnt_q;
      if (c == 4) seq[1] = cnt_q;
      if (c == 8) seq[2] = cnt_q;
      if (c == 12) seq[3] = cnt_q;
      if (state == 3'd2) begin got = c; break; end
    end
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (seq[j] !== 3'(4 + j)) begin
        n_fail++; $display("FAIL arm_cnt_step%0d: got %0d want %0d", j, seq[j], 4 + j);
      end
    end
    n_checks++;
    if (got != 13) begin
      n_fail++; $display("FAIL exit_delay_len: got %0d want 13", got);
    end
  endtask

  task automatic test_intrusion();
    int got;
    apply_reset();
    arm = 1; step(); arm = 0;
    repeat (13) step();
    n_checks++;
    if (state !== 3'd2 || armed_led !== 1'b1) begin
      n_fail++; $display("FAIL armed: got state=%0d led=%0b want 2/1", state, armed_led);
    end
    sensor = 1; step(); sensor = 0;
    n_checks++;
    if (state !== 3'd3 || cnt_load !== 1'b1 || cnt_load_value !== 3'd5) begin
      n_fail++; $display("FAIL entry: got state=%0d load=%0b lv=%0d want 3/1/5", state, cnt_load, cnt_load_value);
    end
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (state == 3'd4) begin got = c; break; end
    end
    n_checks++;
    if (got != 9) begin
      n_fail++; $display("FAIL entry_delay_len: got %0d want 9", got);
    end
    n_checks++;
    if (siren !== 1'b1 || armed_led !== 1'b0 || delay_active !== 1'b0) begin
      n_fail++; $display("FAIL alarm_outputs: got siren=%0b armed=%0b delay=%0b want 1/0/0", siren, armed_led, delay_active);
    end
  endtask

  task automatic test_disarm_race();
    apply_reset();
    arm = 1; step(); arm = 0;
    repeat (12) step();
    n_checks++;
    if (state !== 3'd1 || cnt_q !== 3'd7) begin
      n_fail++; $display("FAIL race_setup: got state=%0d cnt=%0d want 1/7", state, cnt_q);
    end
    disarm = 1; step(); disarm = 0;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL race_expiry: got state=%0d want 0", state);
    end
    arm = 1; step(); arm = 0;
    repeat (13) step();
    disarm = 1; sensor = 1; step(); disarm = 0; sensor = 0;
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL race_sensor: got state=%0d want 0", state);
    end
  endtask

  task automatic test_ignored();
    int got, bad;
    apply_reset();
    arm = 1; step(); arm = 0;
    got = 0;
    for (int c = 1; c <= 20; c++) begin
      sensor = ~sensor;
      step();
      if (state == 3'd2) begin got = c; break; end
    end
    sensor = 0;
    n_checks++;
    if (got != 13) begin
      n_fail++; $display("FAIL sensor_ignored_exit: got %0d want 13", got);
    end
    sensor = 1; step(); sensor = 0;
    repeat (9) step();
    arm = 1; bad = 0;
    repeat (12) begin
      sensor = 1'($urandom);
      step();
      if (siren !== 1'b1 || state !== 3'd4) bad++;
    end
    arm = 0; sensor = 0;
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL alarm_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_rearm();
    int got;
    apply_reset();
    arm = 1; step(); arm = 0;
    repeat (5) step();
    disarm = 1; step(); disarm = 0;
    n_checks++;
    if (state !== 3'd0 || cnt_q !== 3'd5) begin
      n_fail++; $display("FAIL abort: got state=%0d cnt=%0d want 0/5", state, cnt_q);
    end
    repeat (3) step();
    n_checks++;
    if (cnt_q !== 3'd5) begin
      n_fail++; $display("FAIL abort_hold: got cnt=%0d want 5", cnt_q);
    end
    arm = 1; step(); arm = 0;
    n_checks++;
    if (state !== 3'd1 || cnt_load !== 1'b1 || cnt_load_value !== 3'd4) begin
      n_fail++; $display("FAIL rearm_entry: got state=%0d load=%0b lv=%0d want 1/1/4", state, cnt_load, cnt_load_value);
    end
    step();
    n_checks++;
    if (cnt_q !== 3'd4) begin
      n_fail++; $display("FAIL rearm_reload: got cnt=%0d want 4", cnt_q);
    end
    got = 0;
    for (int c = 2; c <= 20; c++) begin
      step();
      if (state == 3'd2) begin got = c; break; end
    end
    n_checks++;
    if (got != 13) begin
      n_fail++; $display("FAIL rearm_delay_len: got %0d want 13", got);
    end
  endtask

  task automatic test_random();
    bit exp_en;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      arm    = ($urandom_range(0, 9) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      sensor = ($urandom_range(0, 7) == 0);
      step();
      exp_en = (m_st == 1 || m_st == 3) && !m_load && (m_k % TD == TD - 1) && (m_cnt != CMAX);
      n_checks++;
      if (state !== 3'(m_st)) begin n_fail++; $display("FAIL rnd_state cyc %0d: got %0d want %0d", i, state, m_st); end
      n_checks++;
      if (cnt_load !== m_load) begin n_fail++; $display("FAIL rnd_load cyc %0d: got %0b want %0b", i, cnt_load, m_load); end
      n_checks++;
      if (cnt_load_value !== 3'(m_lv)) begin n_fail++; $display("FAIL rnd_lv cyc %0d: got %0d want %0d", i, cnt_load_value, m_lv); end
      n_checks++;
      if (cnt_q !== 3'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", i, cnt_q, m_cnt); end
      n_checks++;
      if (cnt_en !== exp_en) begin n_fail++; $display("FAIL rnd_en cyc %0d: got %0b want %0b", i, cnt_en, exp_en); end
      n_checks++;
      if (armed_led !== (m_st == 2 || m_st == 3)) begin n_fail++; $display("FAIL rnd_armed cyc %0d: got %0b", i, armed_led); end
      n_checks++;
      if (delay_active !== (m_st == 1 || m_st == 3)) begin n_fail++; $display("FAIL rnd_delay cyc %0d: got %0b", i, delay_active); end
      n_checks++;
      if (siren !== (m_st == 4)) begin n_fail++; $display("FAIL rnd_siren cyc %0d: got %0b", i, siren); end
    end
    arm = 0; disarm = 0; sensor = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arm();
    test_intrusion();
    test_disarm_race();
    test_ignored();
    test_rearm();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
